// File: rtl/dht_pkg.sv
// Shared definitions for the single-wire DHT11/DHT22 frame reader.
//   state_e     : reader FSM state encoding
//   ERR_*       : error_code values reported to the host
//   MODE_*      : sensor family selected by the mode input
//   us_to_cyc() : time-to-cycle conversion done in 64 bits so that
//                 long times at fast clocks do not overflow
package dht_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StStartLow,
        StRelease,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StCheck,
        StHoldoff
    } state_e;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_NO_RESP     = 3'd1;
    localparam logic [2:0] ERR_RESP_TIMING = 3'd2;
    localparam logic [2:0] ERR_BIT_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM    = 3'd4;

    localparam logic MODE_DHT11 = 1'b0;
    localparam logic MODE_DHT22 = 1'b1;

    function automatic logic [31:0] us_to_cyc(input logic [63:0] amount,
                                              input logic [63:0] clk_hz,
                                              input logic [63:0] per_sec);
        logic [63:0] prod;
        prod = amount * clk_hz / per_sec;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/dht_frame_reader_tristate.sv
// TriState: open-drain pad cell for the sensor line.
//   pad_io      : bidirectional pad
//   drive_low_i : 1 pulls the pad low, 0 releases it (external pull-up)
//   in_o        : raw (unsynchronised) pad value
module TriState (
    inout  wire  pad_io,
    input  logic drive_low_i,
    output logic in_o
);

    assign pad_io = drive_low_i ? 1'b0 : 1'bz;
    assign in_o   = pad_io;

endmodule

// File: rtl/dht_frame_reader.sv
// dht_frame_reader: reads one 40-bit DHT11/DHT22 frame per start request,
// verifies the checksum and decodes humidity/temperature.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, mode           : one-cycle request; mode 0=DHT11, 1=DHT22 (latched)
//   transmission_line     : open-drain sensor line
//   busy, done            : transaction/holdoff in progress; end-of-transaction pulse
//   data_valid, error_code: last result status
//   retry_count           : retries consumed by the last transaction
//   raw, humidity, temperature : last good frame and its decoded values
// Build option: define DHT_RETRY_EN to retry failed transactions automatically.
module dht_frame_reader
    import dht_pkg::*;
#(
    parameter int unsigned CLK_HZ             = 50_000_000,
    parameter int unsigned START_LOW_DHT11_US = 18000,
    parameter int unsigned START_LOW_DHT22_US = 1000,
    parameter int unsigned BIT_THRESH_US      = 50,
    parameter int unsigned TIMEOUT_US         = 200,
    parameter int unsigned HOLDOFF_MS         = 1000,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    inout  wire         transmission_line,
    output logic        busy,
    output logic        done,
    output logic        data_valid,
    output logic [2:0]  error_code,
    output logic [1:0]  retry_count,
    output logic [39:0] raw,
    output logic [15:0] humidity,
    output logic [15:0] temperature
);

    localparam logic [31:0] START11_CYC =
        us_to_cyc(64'(START_LOW_DHT11_US), 64'(CLK_HZ), 64'd1_000_000);
    localparam logic [31:0] START22_CYC =
        us_to_cyc(64'(START_LOW_DHT22_US), 64'(CLK_HZ), 64'd1_000_000);
    localparam logic [31:0] THRESH_CYC  =
        us_to_cyc(64'(BIT_THRESH_US), 64'(CLK_HZ), 64'd1_000_000);
    localparam logic [31:0] TIMEOUT_CYC =
        us_to_cyc(64'(TIMEOUT_US), 64'(CLK_HZ), 64'd1_000_000);
    localparam logic [31:0] HOLDOFF_CYC =
        us_to_cyc(64'(HOLDOFF_MS), 64'(CLK_HZ), 64'd1_000);

    logic line_in;
    logic drive_low;

    TriState u_pad (
        .pad_io      (transmission_line),
        .drive_low_i (drive_low),
        .in_o        (line_in)
    );

    state_e      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [39:0] shift_q, shift_d;
    logic        mode_q, mode_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [2:0]  err_q, err_d;
    logic [39:0] raw_q, raw_d;
    logic [15:0] hum_q, hum_d;
    logic [15:0] temp_q, temp_d;
`ifdef DHT_RETRY_EN
    localparam logic [1:0] RETRY_LIM = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);
    logic [1:0]  tries_q, tries_d;
    logic        pend_q, pend_d;
    logic [1:0]  retry_q, retry_d;
`endif

    // sync_q[1] is the synchronised line, sync_q[2] its previous value.
    logic fall, rise, timed_out, bit_val;
    logic [31:0] start_cyc;
    assign sync_d    = {sync_q[1:0], line_in};
    assign fall      = sync_q[2] & ~sync_q[1];
    assign rise      = ~sync_q[2] & sync_q[1];
    assign timed_out = (cnt_q >= TIMEOUT_CYC - 32'd1);
    // cnt_q + 1 cycles of high time have elapsed when the fall is seen.
    assign bit_val   = (cnt_q >= THRESH_CYC);
    assign start_cyc = (mode_q == MODE_DHT11) ? START11_CYC : START22_CYC;
    assign drive_low = (state_q == StStartLow);

    // Frame decode.
    logic [7:0]  b4, b3, b2, b1, b0, csum;
    logic [15:0] mag, hum_dec, temp_dec;
    assign {b4, b3, b2, b1, b0} = shift_q;
    assign csum = b4 + b3 + b2 + b1;

    always_comb begin
        mag = {1'b0, b2[6:0], b1};
        if (mode_q == MODE_DHT22) begin
            hum_dec  = {b4, b3};
            temp_dec = b2[7] ? (16'd0 - mag) : mag;
        end else begin
            hum_dec  = 16'(b4) * 16'd10 + 16'(b3);
            temp_dec = 16'(b2) * 16'd10 + 16'(b1);
        end
    end

    logic       fail;
    logic [2:0] fail_code;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        err_d     = err_q;
        raw_d     = raw_q;
        hum_d     = hum_q;
        temp_d    = temp_q;
        fail      = 1'b0;
        fail_code = ERR_NONE;
`ifdef DHT_RETRY_EN
        tries_d   = tries_q;
        pend_d    = pend_q;
        retry_d   = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StStartLow;
                    mode_d  = mode;
`ifdef DHT_RETRY_EN
                    tries_d = '0;
                    pend_d  = 1'b0;
`endif
                end
            end
            StStartLow: begin
                if (cnt_q >= start_cyc - 32'd1) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (fall) begin
                    state_d = StRespLow;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_NO_RESP;
                end
            end
            StRespLow: begin
                if (rise) begin
                    state_d = StRespHigh;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_RESP_TIMING;
                end
            end
            StRespHigh: begin
                if (fall) begin
                    state_d = StBitLow;
                    cnt_d   = '0;
                    idx_d   = 6'd39;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_RESP_TIMING;
                end
            end
            StBitLow: begin
                if (rise) begin
                    state_d = StBitHigh;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT_TIMEOUT;
                end
            end
            StBitHigh: begin
                if (fall) begin
                    shift_d = {shift_q[38:0], bit_val};
                    cnt_d   = '0;
                    if (idx_q == 6'd0) begin
                        state_d = StCheck;
                    end else begin
                        idx_d   = idx_q - 6'd1;
                        state_d = StBitLow;
                    end
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT_TIMEOUT;
                end
            end
            StCheck: begin
                if (csum == b0) begin
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    err_d   = ERR_NONE;
                    raw_d   = shift_q;
                    hum_d   = hum_dec;
                    temp_d  = temp_dec;
                    state_d = StHoldoff;
                    cnt_d   = '0;
`ifdef DHT_RETRY_EN
                    retry_d = tries_q;
`endif
                end else begin
                    fail      = 1'b1;
                    fail_code = ERR_CHECKSUM;
                end
            end
            StHoldoff: begin
                if (cnt_q >= HOLDOFF_CYC - 32'd1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
`ifdef DHT_RETRY_EN
                    if (pend_q) begin
                        state_d = StStartLow;
                        pend_d  = 1'b0;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Every failure goes through holdoff; only the final one is reported.
        if (fail) begin
            state_d = StHoldoff;
            cnt_d   = '0;
`ifdef DHT_RETRY_EN
            if (tries_q < RETRY_LIM) begin
                tries_d = tries_q + 2'd1;
                pend_d  = 1'b1;
            end else begin
                done_d  = 1'b1;
                valid_d = 1'b0;
                err_d   = fail_code;
                retry_d = tries_q;
            end
`else
            done_d  = 1'b1;
            valid_d = 1'b0;
            err_d   = fail_code;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            sync_q  <= 3'b111;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            mode_q  <= MODE_DHT11;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= ERR_NONE;
            raw_q   <= '0;
            hum_q   <= '0;
            temp_q  <= '0;
`ifdef DHT_RETRY_EN
            tries_q <= '0;
            pend_q  <= 1'b0;
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            raw_q   <= raw_d;
            hum_q   <= hum_d;
            temp_q  <= temp_d;
`ifdef DHT_RETRY_EN
            tries_q <= tries_d;
            pend_q  <= pend_d;
            retry_q <= retry_d;
`endif
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign data_valid  = valid_q;
    assign error_code  = err_q;
    assign raw         = raw_q;
    assign humidity    = hum_q;
    assign temperature = temp_q;
`ifdef DHT_RETRY_EN
    assign retry_count = retry_q;
`else
    assign retry_count = 2'd0;
`endif

endmodule

// File: tb/tb_dht_frame_reader.sv
module tb_dht_frame_reader;

    localparam int S11  = 500;
    localparam int S22  = 100;
    localparam int HOLD = 1000;
    localparam int TMO  = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        sensor_low = 1'b0;
    wire         line;
    logic        busy, done, data_valid;
    logic [2:0]  error_code;
    logic [1:0]  retry_count;
    logic [39:0] raw;
    logic [15:0] humidity, temperature;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int pulse_cnt = 0;
    logic dut_low_q = 1'b0;

    pullup (line);
    assign line = sensor_low ? 1'b0 : 1'bz;

    dht_frame_reader #(
        .CLK_HZ             (1_000_000),
        .START_LOW_DHT11_US (S11),
        .START_LOW_DHT22_US (S22),
        .BIT_THRESH_US      (50),
        .TIMEOUT_US         (TMO),
        .HOLDOFF_MS         (1),
        .MAX_RETRIES        (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .mode              (mode),
        .transmission_line (line),
        .busy              (busy),
        .done              (done),
        .data_valid        (data_valid),
        .error_code        (error_code),
        .retry_count       (retry_count),
        .raw               (raw),
        .humidity          (humidity),
        .temperature       (temperature)
    );

    always #5 clock = ~clock;

    // Count done pulses and host start pulses (line low while sensor releases it).
    always @(negedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        dut_low_q <= (line === 1'b0) && !sensor_low;
        if ((line === 1'b0) && !sensor_low && !dut_low_q) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic sensor_drive(input logic low, input int n);
        sensor_low = low;
        repeat (n) @(negedge clock);
    endtask

    // Measure the host start pulse, which must already be present.
    task automatic sense_start_low(input int exp_len);
        int c = 0;
        while (line === 1'b0 && c < 20000) begin
            @(negedge clock);
            c++;
        end
        check("start_low_len", 64'(c), 64'(exp_len));
    endtask

    // Response plus bits 39 down to 40-nbits; ends with the line released (high).
    task automatic send_frame(input logic [39:0] f, input int nbits);
        sensor_drive(1'b0, 20);
        sensor_drive(1'b1, 80);
        sensor_drive(1'b0, 80);
        for (int i = 39; i > 39 - nbits; i--) begin
            sensor_drive(1'b1, 50);
            sensor_drive(1'b0, f[i] ? 70 : 26);
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge clock);
            cyc++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        while (busy === 1'b1 && c < limit) begin
            @(negedge clock);
            c++;
        end
        check("busy_drop", {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic        mode;
        logic [39:0] frame;
        logic        exp_valid;
        logic [2:0]  exp_err;
        logic [1:0]  exp_retry;
        logic [15:0] exp_hum;
        logic [15:0] exp_temp;
        logic [39:0] exp_raw;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int d0, p0, cyc;

        vecs[0] = '{"dht11_ok", 1'b0, 40'h37_00_19_05_55, 1'b1, 3'd0, 2'd0,
                    16'd550, 16'd255, 40'h37_00_19_05_55};
        vecs[1] = '{"dht22_ok", 1'b1, 40'h02_8C_80_65_73, 1'b1, 3'd0, 2'd0,
                    16'd652, 16'hFF9B, 40'h02_8C_80_65_73};
`ifdef DHT_RETRY_EN
        // Sensor holds the line low after the bad frame, so retries see no response.
        vecs[2] = '{"dht11_csum", 1'b0, 40'h37_00_19_05_56, 1'b0, 3'd1, 2'd3,
                    16'd652, 16'hFF9B, 40'h02_8C_80_65_73};
`else
        vecs[2] = '{"dht11_csum", 1'b0, 40'h37_00_19_05_56, 1'b0, 3'd4, 2'd0,
                    16'd652, 16'hFF9B, 40'h02_8C_80_65_73};
`endif

        // Reset, with start asserted alongside it: reset wins.
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_valid", {63'd0, data_valid}, 64'd0);
        check("rst_err", 64'(error_code), 64'd0);
        check("rst_retry", 64'(retry_count), 64'd0);
        check("rst_raw", 64'(raw), 64'd0);
        check("rst_hum", 64'(humidity), 64'd0);
        check("rst_temp", 64'(temperature), 64'd0);
        check("rst_line", {63'd0, line}, 64'd1);

        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt;
            p0 = pulse_cnt;
            mode = vecs[i].mode;
            pulse_start();
            mode = ~vecs[i].mode;  // must not affect the running transaction
            check({vecs[i].name, "_busy_rise"}, {63'd0, busy}, 64'd1);
            sense_start_low(vecs[i].mode ? S22 : S11);
            send_frame(vecs[i].frame, 40);
            sensor_low = 1'b1;
            wait_done(8000, cyc);
            check({vecs[i].name, "_busy_at_done"}, {63'd0, busy}, 64'd1);
            check({vecs[i].name, "_valid"}, {63'd0, data_valid}, {63'd0, vecs[i].exp_valid});
            check({vecs[i].name, "_err"}, 64'(error_code), 64'(vecs[i].exp_err));
            check({vecs[i].name, "_retry"}, 64'(retry_count), 64'(vecs[i].exp_retry));
            check({vecs[i].name, "_hum"}, 64'(humidity), 64'(vecs[i].exp_hum));
            check({vecs[i].name, "_temp"}, 64'(temperature), 64'(vecs[i].exp_temp));
            check({vecs[i].name, "_raw"}, 64'(raw), 64'(vecs[i].exp_raw));
            sensor_drive(1'b1, 30);
            sensor_low = 1'b0;
            wait_idle(HOLD + 100);
            repeat (2) @(negedge clock);
            check({vecs[i].name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
            check({vecs[i].name, "_start_pulses"}, 64'(pulse_cnt - p0), 64'd1);
        end

        // Reset during the high phase of bit 20 discards everything.
        mode = 1'b0;
        pulse_start();
        sense_start_low(S11);
        send_frame(40'h37_00_19_05_55, 19);
        sensor_drive(1'b1, 50);
        sensor_drive(1'b0, 10);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_line", {63'd0, line}, 64'd1);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_valid", {63'd0, data_valid}, 64'd0);
        check("midrst_raw", 64'(raw), 64'd0);
        check("midrst_hum", 64'(humidity), 64'd0);
        check("midrst_temp", 64'(temperature), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Extra start pulses while busy are ignored.
        d0 = done_cnt;
        p0 = pulse_cnt;
        pulse_start();
        pulse_start();
        sense_start_low(S11 - 2);
        send_frame(40'h37_00_19_05_55, 40);
        sensor_low = 1'b1;
        wait_done(8000, cyc);
        sensor_drive(1'b1, 30);
        sensor_low = 1'b0;
        pulse_start();
        wait_idle(HOLD + 100);
        repeat (2) @(negedge clock);
        check("ignore_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("ignore_start_pulses", 64'(pulse_cnt - p0), 64'd1);
        check("ignore_hum", 64'(humidity), 64'd550);
        check("ignore_valid", {63'd0, data_valid}, 64'd1);

        // Sensor never answers.
        d0 = done_cnt;
        pulse_start();
        wait_done(8000, cyc);
`ifdef DHT_RETRY_EN
        check("noresp_latency", 64'(cyc), 64'(3 * (S11 + TMO + HOLD) + S11 + TMO));
        check("noresp_retry", 64'(retry_count), 64'd3);
`else
        check("noresp_latency", 64'(cyc), 64'(S11 + TMO));
        check("noresp_retry", 64'(retry_count), 64'd0);
`endif
        check("noresp_err", 64'(error_code), 64'd1);
        check("noresp_valid", {63'd0, data_valid}, 64'd0);
        check("noresp_hum_kept", 64'(humidity), 64'd550);
        wait_idle(HOLD + 100);
        repeat (2) @(negedge clock);
        check("noresp_done_pulses", 64'(done_cnt - d0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
